cache_controller: RTL and testbench

Sequencing FSM for the direct-mapped write-back data cache in the single-cycle CPU. It sits between the CPU memory port, the cache array and the 128-bit-line data memory. It resolves hits in the same cycle, stalls the CPU on misses, writes back dirty victims, refills lines and keeps saturating hit/miss/write-back counters.

---
 rtl/cache_ctrl_pkg.sv | 22 ++
 rtl/cache_controller_sat_counter.sv | 21 ++
 rtl/cache_controller.sv | 144 ++++++++++++++
 tb/tb_cache_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the data-cache sequencing controller.
package cache_ctrl_pkg;

  localparam int unsigned LINE_OFFSET_BITS = 2;
  localparam int unsigned MAX_ADDR_WIDTH   = 64;
  localparam int unsigned WORD_WIDTH       = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  localparam logic [MAX_ADDR_WIDTH-1:0] OFFSET_MASK =
    MAX_ADDR_WIDTH'((64'd1 << LINE_OFFSET_BITS) - 64'd1);

  // Line-aligned address: word-in-line offset bits cleared.
  function automatic logic [MAX_ADDR_WIDTH-1:0] line_addr(input logic [MAX_ADDR_WIDTH-1:0] a);
    return a & ~OFFSET_MASK;
  endfunction

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Saturating event counter with synchronous reset and clear.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear wins over increment; stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Miss sequencing for the direct-mapped write-back data cache: hit, write-back, refill.
module cache_controller
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_stall,
  input  logic                  cache_hit,
  input  logic                  cache_valid_idx,
  input  logic                  cache_dirty_idx,
  input  logic [ADDR_WIDTH-1:0] victim_addr,
  output logic                  cache_we,
  output logic                  cache_wr_mem,
  output logic                  cache_rd_en,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt,
  output logic [CNT_WIDTH-1:0]  wb_cnt
);

  // A line must hold exactly the words addressed by the offset bits.
  if (LINE_WIDTH != (WORD_WIDTH << LINE_OFFSET_BITS)) begin : g_bad_line_width
    $error("LINE_WIDTH does not match LINE_OFFSET_BITS");
  end

  state_t state;
  state_t state_nxt;

  logic req;
  logic is_store;
  logic hit_inc;
  logic miss_inc;
  logic wb_inc;

  logic [ADDR_WIDTH-1:0] victim_line;
  logic [ADDR_WIDTH-1:0] cpu_line;

  assign req      = cpu_rd | cpu_wr;
  assign is_store = cpu_wr;

  assign victim_line = ADDR_WIDTH'(line_addr(MAX_ADDR_WIDTH'(victim_addr)));
  assign cpu_line    = ADDR_WIDTH'(line_addr(MAX_ADDR_WIDTH'(cpu_addr)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and combinational output decode.
  always_comb begin
    state_nxt    = state;
    cpu_stall    = 1'b0;
    cache_we     = 1'b0;
    cache_wr_mem = 1'b0;
    cache_rd_en  = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    wb_inc       = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          if (cache_hit) begin
            hit_inc      = 1'b1;
            cache_we     = is_store;
            cache_wr_mem = is_store;
          end else begin
            cpu_stall = 1'b1;
            miss_inc  = 1'b1;
            state_nxt = (cache_valid_idx && cache_dirty_idx) ? WRITEBACK : REFILL;
          end
        end
      end

      WRITEBACK: begin
        cpu_stall   = 1'b1;
        cache_rd_en = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = victim_line;
        if (mem_ready) begin
          wb_inc    = 1'b1;
          state_nxt = REFILL;
        end
      end

      REFILL: begin
        cpu_stall = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = cpu_line;
        // Line fill lands in the ready cycle; the store word (if any) follows as a hit.
        if (mem_ready) begin
          cache_we  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (hit_inc),
    .count(hit_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (miss_inc),
    .count(miss_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (wb_inc),
    .count(wb_cnt)
  );

endmodule

// File: tb/tb_cache_controller.sv
// Transaction-scripted random bench for cache_controller; two instances differ only in counter width.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr;
  logic        cache_hit, cache_valid_idx, cache_dirty_idx;
  logic [31:0] victim_addr;
  logic        mem_ready;
  logic        cnt_clr;

  logic        stall, we, wrm, rden, mrd, mwr;
  logic [31:0] maddr;
  logic [15:0] hc, mc, wc;

  logic        s_stall, s_we, s_wrm, s_rden, s_mrd, s_mwr;
  logic [31:0] s_maddr;
  logic [3:0]  s_hc, s_mc, s_wc;

  int n_tests = 0;
  int n_fail  = 0;
  int m_hit   = 0;
  int m_miss  = 0;
  int m_wb    = 0;
  bit clr_en  = 1'b0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_stall(stall), .cache_hit(cache_hit), .cache_valid_idx(cache_valid_idx),
    .cache_dirty_idx(cache_dirty_idx), .victim_addr(victim_addr), .cache_we(we),
    .cache_wr_mem(wrm), .cache_rd_en(rden), .mem_rd(mrd), .mem_wr(mwr),
    .mem_addr(maddr), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .hit_cnt(hc), .miss_cnt(mc), .wb_cnt(wc)
  );

  cache_controller #(.CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_stall(s_stall), .cache_hit(cache_hit), .cache_valid_idx(cache_valid_idx),
    .cache_dirty_idx(cache_dirty_idx), .victim_addr(victim_addr), .cache_we(s_we),
    .cache_wr_mem(s_wrm), .cache_rd_en(s_rden), .mem_rd(s_mrd), .mem_wr(s_mwr),
    .mem_addr(s_maddr), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .hit_cnt(s_hc), .miss_cnt(s_mc), .wb_cnt(s_wc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int maxv);
    return (v > maxv) ? 32'(maxv) : 32'(v);
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic pick_clr();
    cnt_clr = clr_en && ($urandom_range(15) == 0);
  endtask

  // One clock: e = {stall, cache_we, cache_wr_mem, cache_rd_en, mem_rd, mem_wr}.
  task automatic cycle(input logic [5:0] e, input logic [31:0] ea,
                       input bit ih, input bit im, input bit iw);
    @(negedge clk);
    check("cpu_stall",    32'(stall), 32'(e[5]));
    check("cache_we",     32'(we),    32'(e[4]));
    check("cache_wr_mem", 32'(wrm),   32'(e[3]));
    check("cache_rd_en",  32'(rden),  32'(e[2]));
    check("mem_rd",       32'(mrd),   32'(e[1]));
    check("mem_wr",       32'(mwr),   32'(e[0]));
    check("mem_addr",     maddr,      ea);
    check("s_cpu_stall",  32'(s_stall), 32'(e[5]));
    check("s_cache_we",   32'(s_we),    32'(e[4]));
    check("s_cache_wr_mem", 32'(s_wrm), 32'(e[3]));
    check("s_cache_rd_en", 32'(s_rden), 32'(e[2]));
    check("s_mem_rd",     32'(s_mrd),   32'(e[1]));
    check("s_mem_wr",     32'(s_mwr),   32'(e[0]));
    check("s_mem_addr",   s_maddr,      ea);
    check("hit_cnt",      32'(hc),   sat(m_hit, 65535));
    check("miss_cnt",     32'(mc),   sat(m_miss, 65535));
    check("wb_cnt",       32'(wc),   sat(m_wb, 65535));
    check("s_hit_cnt",    32'(s_hc), sat(m_hit, 15));
    check("s_miss_cnt",   32'(s_mc), sat(m_miss, 15));
    check("s_wb_cnt",     32'(s_wc), sat(m_wb, 15));
    if (rst || cnt_clr) begin
      m_hit = 0; m_miss = 0; m_wb = 0;
    end else begin
      m_hit += int'(ih); m_miss += int'(im); m_wb += int'(iw);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    cache_hit = 1'($urandom); mem_ready = 1'($urandom);
    pick_clr();
    cycle(6'b000000, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // kind: 0 load, 1 store, 2 load+store. drop releases the request once the refill starts.
  task automatic txn(input int kind, input bit miss, input bit dirty, input int w, input int n,
                     input logic [31:0] a, input logic [31:0] v, input bit drop);
    bit st;
    st = (kind != 0);
    cpu_rd = (kind != 1); cpu_wr = (kind != 0);
    cpu_addr = a; victim_addr = v;
    if (!miss) begin
      cache_hit = 1'b1; cache_valid_idx = 1'b1; cache_dirty_idx = 1'($urandom);
      mem_ready = 1'($urandom); pick_clr();
      cycle({1'b0, st, st, 3'b000}, 32'h0, 1'b1, 1'b0, 1'b0);
    end else begin
      cache_hit = 1'b0;
      if (dirty) begin
        cache_valid_idx = 1'b1; cache_dirty_idx = 1'b1;
      end else begin
        case ($urandom_range(2))
          0: begin cache_valid_idx = 1'b0; cache_dirty_idx = 1'b0; end
          1: begin cache_valid_idx = 1'b0; cache_dirty_idx = 1'b1; end
          default: begin cache_valid_idx = 1'b1; cache_dirty_idx = 1'b0; end
        endcase
      end
      mem_ready = 1'($urandom); pick_clr();
      cycle(6'b100000, 32'h0, 1'b0, 1'b1, 1'b0);
      if (dirty) begin
        for (int i = 0; i < w; i++) begin
          mem_ready = (i == w - 1); cache_hit = 1'($urandom); pick_clr();
          cycle(6'b100101, line_of(v), 1'b0, 1'b0, (i == w - 1));
        end
      end
      for (int i = 0; i < n; i++) begin
        if (drop) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
        mem_ready = (i == n - 1); cache_hit = 1'($urandom); pick_clr();
        cycle({1'b1, (i == n - 1), 4'b0010}, line_of(a), 1'b0, 1'b0, 1'b0);
      end
      mem_ready = 1'($urandom); pick_clr();
      if (drop) begin
        cache_hit = 1'($urandom);
        cycle(6'b000000, 32'h0, 1'b0, 1'b0, 1'b0);
      end else begin
        cache_hit = 1'b1;
        cycle({1'b0, st, st, 3'b000}, 32'h0, 1'b1, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0;
    cache_hit = 1'b0; cache_valid_idx = 1'b0; cache_dirty_idx = 1'b0;
    victim_addr = '0; mem_ready = 1'b0; cnt_clr = 1'b0;
    @(posedge clk); #1;
    cycle(6'b000000, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    txn(0, 1'b0, 1'b0, 0, 0, 32'h10, 32'h0, 1'b0);
    idle();
    txn(0, 1'b1, 1'b0, 0, 3, 32'h24, 32'h0, 1'b0);
    idle();
    txn(1, 1'b1, 1'b1, 2, 2, 32'h08, 32'h48, 1'b0);
    idle();
    txn(2, 1'b0, 1'b0, 0, 0, 32'h3C, 32'h0, 1'b0);
    txn(0, 1'b1, 1'b1, 1, 2, 32'h1234_5677, 32'h0ABC_DEF3, 1'b1);
    idle();

    // Reset during the second refill cycle.
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h30; victim_addr = 32'h0;
    cache_hit = 1'b0; cache_valid_idx = 1'b0; cache_dirty_idx = 1'b0; mem_ready = 1'b0;
    cycle(6'b100000, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(6'b100010, 32'h30, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle(6'b100010, 32'h30, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; cache_hit = 1'b1;
    cycle(6'b000000, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // Saturation of the 4-bit instance, then clear colliding with a hit.
    cnt_clr = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cycle(6'b000000, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) txn(0, 1'b0, 1'b0, 0, 0, 32'(i * 4), 32'h0, 1'b0);
    cpu_rd = 1'b1; cache_hit = 1'b1; cnt_clr = 1'b1;
    cycle(6'b000000, 32'h0, 1'b1, 1'b0, 1'b0);
    cnt_clr = 1'b0;
    idle();

    clr_en = 1'b1;
    for (int t = 0; t < 150; t++) begin
      txn(int'($urandom_range(2)), 1'($urandom), 1'($urandom),
          int'($urandom_range(4, 1)), int'($urandom_range(4, 1)),
          $urandom, $urandom, ($urandom_range(7) == 0));
      for (int k = 0; k < int'($urandom_range(2)); k++) idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
